// File: rtl/sramlike_bridge.sv
// sramlike_bridge
// Bridges the core's single-cycle SRAM-style port onto a split-handshake
// SRAM-like bus (req / addr_ok / data_ok). One bridge sits on each of the
// instruction and data sides. The core is stalled while a transaction is in
// flight. The returned data is held in DONE for as long as another stall
// source keeps the pipeline frozen.
//
// Optional build macro: BRIDGE_PERF_CNT_EN
//   defined   : req_cnt counts accepted requests and stall_cnt counts cycles
//               with cpu_stall high. Both are 32-bit wrapping counters.
//   undefined : req_cnt and stall_cnt are tied to zero.

module sramlike_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  cpu_en,
   input  logic [DATA_W/8-1:0]   cpu_wen,
   input  logic [ADDR_W-1:0]     cpu_addr,
   input  logic [DATA_W-1:0]     cpu_wdata,
   output logic [DATA_W-1:0]     cpu_rdata,
   output logic                  cpu_stall,
   input  logic                  pipe_stall,
   input  logic                  flush,

   output logic                  mem_req,
   output logic                  mem_wr,
   output logic [1:0]            mem_size,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_addr_ok,
   input  logic                  mem_data_ok,
   input  logic [DATA_W-1:0]     mem_rdata,

   output logic [31:0]           req_cnt,
   output logic [31:0]           stall_cnt
);

   localparam int         BE_W      = DATA_W / 8;
   localparam logic [1:0] FULL_SIZE = (DATA_W == 64) ? 2'd3 : 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic take_req;
   logic take_rsp;

   // Translate the byte-enable pattern into a bus transfer size. Reads,
   // full-width writes and irregular strobe patterns all use the full
   // width. The byte strobes downstream sort out the irregular writes.
   function automatic logic [1:0] size_of(input logic [BE_W-1:0] wen);
      logic [1:0] sz;
      sz = FULL_SIZE;
      if (wen != '0 && wen != '1) begin
         for (int i = 0; i < BE_W; i++) begin
            if (wen == (BE_W'(1) << i)) begin
               sz = 2'd0;
            end
         end
         for (int i = 0; i < BE_W; i += 2) begin
            if (wen == (BE_W'(3) << i)) begin
               sz = 2'd1;
            end
         end
         if (BE_W == 8) begin
            for (int i = 0; i < BE_W; i += 4) begin
               if (wen == (BE_W'(15) << i)) begin
                  sz = 2'd2;
               end
            end
         end
      end
      return sz;
   endfunction

   // State register; reset abandons any in-flight transaction without retry.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic plus the handshake outputs that depend only on state.
   always_comb begin
      state_next = state;
      mem_req    = 1'b0;
      cpu_stall  = 1'b0;
      take_req   = 1'b0;
      take_rsp   = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_en) begin
               cpu_stall  = 1'b1;
               take_req   = 1'b1;
               state_next = ADDR;
            end
         end
         ADDR: begin
            mem_req   = 1'b1;
            cpu_stall = 1'b1;
            if (mem_addr_ok) begin
               state_next = DATA;
            end
         end
         DATA: begin
            cpu_stall = 1'b1;
            if (mem_data_ok) begin
               take_rsp   = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (!pipe_stall || flush) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Request fields are captured once on acceptance and stay fixed until the next request.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_wr    <= 1'b0;
         mem_size  <= 2'd0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (take_req) begin
         mem_wr    <= |cpu_wen;
         mem_size  <= size_of(cpu_wen);
         mem_addr  <= cpu_addr;
         mem_wdata <= cpu_wdata;
      end
   end

   // Read data is latched only on a read response in DATA; write acks leave it alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rdata <= '0;
      end else if (take_rsp && !mem_wr) begin
         cpu_rdata <= mem_rdata;
      end
   end

`ifdef BRIDGE_PERF_CNT_EN
   // Performance counters; these wrap freely at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_cnt   <= 32'd0;
         stall_cnt <= 32'd0;
      end else begin
         if (take_req) begin
            req_cnt <= req_cnt + 32'd1;
         end
         if (cpu_stall) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end
`else
   assign req_cnt   = 32'd0;
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/sramlike_bridge.md
Name: sramlike_bridge

Overview:
- Converts the core's single-cycle SRAM-style port (en/wen/addr/wdata/rdata) into a split-handshake SRAM-like bus (req/addr_ok/data_ok).
- Produces a stall back to the pipeline while a transaction is in flight.
- Instantiated once per side (inst, data) between the mips core and the bus/cache layer in the next-generation CPU top.
- Parametrised in address and data width; buffers returned data across external pipeline stalls.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; legal values 32 or 64; byte-enable width is DATA_W/8

Ports:
clk  in  1  sole clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cpu_en  in  1  core request valid; core holds en/wen/addr/wdata stable while cpu_stall=1
cpu_wen  in  DATA_W/8  byte write enables; all-zero means read
cpu_addr  in  ADDR_W  request address
cpu_wdata  in  DATA_W  store data
cpu_rdata  out  DATA_W  load/fetch data; valid while state=DONE
cpu_stall  out  1  stall request to pipeline
pipe_stall  in  1  pipeline held by another source this cycle
flush  in  1  exception flush; discards a completed-but-unconsumed result
mem_req  out  1  bus request
mem_wr  out  1  1=write
mem_size  out  2  0=byte, 1=half, 2=word, 3=dword
mem_addr  out  ADDR_W  registered request address
mem_wdata  out  DATA_W  registered store data
mem_addr_ok  in  1  request accepted this cycle
mem_data_ok  in  1  response (read data or write ack) this cycle
mem_rdata  in  DATA_W  read data, valid with mem_data_ok
req_cnt  out  32  optional-feature counter
stall_cnt  out  32  optional-feature counter

Behaviour:
- States IDLE, ADDR, DATA, DONE. Reset: state=IDLE; mem_req=0; mem_wr=0; mem_size=0; mem_addr=0; mem_wdata=0; cpu_rdata=0; counters=0.
- IDLE: if cpu_en, capture addr, wdata, wr=|cpu_wen and size, then go to ADDR. Otherwise stay.
- ADDR: mem_req=1 with registered fields. On mem_addr_ok, go to DATA. Otherwise hold all fields unchanged.
- DATA: mem_req=0. On mem_data_ok, capture mem_rdata into cpu_rdata (reads only; writes leave it unchanged) and go to DONE.
- DONE: leave for IDLE when pipe_stall=0 or flush=1. Otherwise hold cpu_rdata.
- cpu_stall = (IDLE & cpu_en) | ADDR | DATA. cpu_stall=0 in DONE, so the result is stable for as many cycles as pipe_stall holds the pipeline.
- Minimum latency: request seen cycle 0, addr_ok cycle 1, data_ok cycle 2, DONE cycle 3. That is 3 stall cycles.
- mem_data_ok is only honoured in DATA. It is ignored in IDLE/ADDR/DONE, which covers stale responses after reset.
- mem_addr_ok is ignored outside ADDR.
- Size encoding from wen:
  - all ones → word (DATA_W=32) or dword (DATA_W=64)
  - any aligned contiguous pair of bits → 1
  - single bit → 0
  - any aligned 4-bit group when DATA_W=64 → 2
  - read → full width
  - any other pattern → full width, wr=1 (bus uses byte strobes downstream)
- Reset mid-transaction: returns to IDLE next edge, mem_req drops; no retry.
- flush in ADDR/DATA: no effect; the transaction completes, because the bus cannot cancel it.

Optional Feature:
BRIDGE_PERF_CNT_EN:
- Defined: req_cnt increments on each IDLE→ADDR transition. stall_cnt increments every cycle cpu_stall=1. Both wrap at 2^32 and clear on rst.
- Undefined: both ports drive constant 0 and no counter flops exist.

Test Plan:
1. Read, zero-wait: cpu_en=1, wen=0, addr=0xBFC00000; bus gives addr_ok cycle 1 and data_ok cycle 2 with 0x3C1D0001. Required: mem_req high only in cycle 1; mem_size=2, mem_wr=0; cpu_stall high cycles 0–2; cycle 3 cpu_rdata=0x3C1D0001, cpu_stall=0.
2. Byte store with backpressure: wen=0100, addr=0x80000002, wdata=0x00AB0000; addr_ok delayed 4 cycles. Required: mem_req, mem_addr and mem_wdata held stable all 4 cycles; mem_wr=1, mem_size=0; cpu_rdata unchanged.
3. Pipeline hold: read completes while pipe_stall=1 for 5 cycles. Required: state stays DONE, cpu_stall=0, cpu_rdata constant; IDLE the cycle after pipe_stall falls; no second mem_req.
4. Reset mid-DATA: assert rst in DATA, then deliver a stray data_ok in IDLE. Required: all outputs at reset values; cpu_rdata stays 0; no transition.
5. Flush in DONE with pipe_stall=1. Required: IDLE next cycle.
6. Perf counters (macro defined): three back-to-back zero-wait reads. Required: req_cnt=3, stall_cnt=9; with macro undefined both read 0.
